// File: rtl/sl_pkg.sv
// Shared SL fabric types and widths used by the initiator port and its
// response buffer.
package sl_pkg;

  localparam int SL_ADDR_W = 16;
  localparam int SL_DATA_W = 32;
  localparam int SL_ID_W   = 4;

  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [SL_ADDR_W-1:0] addr;
    logic [SL_DATA_W-1:0] wdata;
    logic [SL_ID_W-1:0]   id;
  } SL_REQ;

  typedef struct packed {
    logic                 valid;
    logic [SL_DATA_W-1:0] rdata;
    logic [SL_ID_W-1:0]   id;
  } SL_RES;

  // One host-visible response entry as held in the response buffer.
  typedef struct packed {
    logic [SL_DATA_W-1:0] rdata;
    logic [SL_ID_W-1:0]   id;
  } sl_rsp_t;

endpackage

// File: rtl/sl_rsp_fifo.sv
// Small synchronous circular buffer with wrap-bit pointers; exports its
// occupancy so the owner can do credit accounting.
module sl_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_count == FULL_CNT);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sl_master_port.sv
// SL fabric initiator endpoint: credit-gated request issue, a delay line that
// predicts each response slot, and tail checking into the response buffer.
module sl_master_port
  import sl_pkg::*;
#(
  parameter int ROUND_TRIP = 4,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   host_wr,
  input  logic [SL_ADDR_W-1:0]   host_addr,
  input  logic [SL_DATA_W-1:0]   host_wdata,
  output SL_REQ                  req_down,
  input  SL_RES                  res_down,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [SL_DATA_W-1:0]   rsp_rdata,
  output logic [SL_ID_W-1:0]     rsp_id,
  output logic [$clog2(DEPTH):0] inflight,
  output logic                   err_unexpected,
  output logic                   err_missing,
  output logic                   err_id
);

  localparam int            CW         = $clog2(DEPTH) + 1;
  localparam int            TAIL       = ROUND_TRIP - 1;
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(DEPTH);

  SL_REQ              r_req;
  logic [SL_ID_W-1:0] r_id_ctr;
  logic               r_exp_valid [ROUND_TRIP];
  logic [SL_ID_W-1:0] r_exp_id    [ROUND_TRIP];
  logic [CW-1:0]      r_inflight;
  logic               r_err_unexpected;
  logic               r_err_missing;
  logic               r_err_id;

  logic [CW-1:0]      w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CW:0]        w_credits_used;
  logic               w_issue;
  logic               w_tail_valid;
  logic               w_push;
  sl_rsp_t            w_push_data;
  sl_rsp_t            w_head;

  // A credit is held from issue until the response leaves the buffer.
  assign w_credits_used = {1'b0, r_inflight} + {1'b0, w_fifo_count};
  assign host_ready     = (w_credits_used < CREDIT_MAX);
  assign w_issue        = host_valid && host_ready;
  assign w_tail_valid   = r_exp_valid[TAIL];

  // Credits guarantee room; the full term only matters if that invariant breaks.
  assign w_push = w_tail_valid && (!w_fifo_full || rsp_ready);

  always_comb begin
    w_push_data    = '0;
    w_push_data.id = r_exp_id[TAIL];
    if (res_down.valid) begin
      w_push_data.rdata = res_down.rdata;
      w_push_data.id    = res_down.id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req    <= '0;
      r_id_ctr <= '0;
    end else begin
      r_req.valid <= w_issue;
      if (w_issue) begin
        r_req.wr    <= host_wr;
        r_req.addr  <= host_addr;
        r_req.wdata <= host_wdata;
        r_req.id    <= r_id_ctr;
        r_id_ctr    <= r_id_ctr + SL_ID_W'(1);
      end
    end
  end

  // Entry 0 follows the issued request so the tail lines up with the response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROUND_TRIP; i++) begin
        r_exp_valid[i] <= 1'b0;
        r_exp_id[i]    <= '0;
      end
    end else begin
      r_exp_valid[0] <= r_req.valid;
      r_exp_id[0]    <= r_req.id;
      for (int i = 1; i < ROUND_TRIP; i++) begin
        r_exp_valid[i] <= r_exp_valid[i-1];
        r_exp_id[i]    <= r_exp_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      unique case ({w_issue, w_tail_valid})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_unexpected <= 1'b0;
      r_err_missing    <= 1'b0;
      r_err_id         <= 1'b0;
    end else begin
      if (!w_tail_valid && res_down.valid) begin
        r_err_unexpected <= 1'b1;
      end
      if (w_tail_valid && !res_down.valid) begin
        r_err_missing <= 1'b1;
      end
      if (w_tail_valid && res_down.valid && (res_down.id != r_exp_id[TAIL])) begin
        r_err_id <= 1'b1;
      end
    end
  end

  sl_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(sl_rsp_t))
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (rsp_ready),
    .o_rdata (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign req_down       = r_req;
  assign rsp_valid      = !w_fifo_empty;
  assign rsp_rdata      = w_head.rdata;
  assign rsp_id         = w_head.id;
  assign inflight       = r_inflight;
  assign err_unexpected = r_err_unexpected;
  assign err_missing    = r_err_missing;
  assign err_id         = r_err_id;

endmodule

// File: tb/tb_sl_master_port.sv
// Bench for sl_master_port: a fixed-latency fabric model with fault knobs and
// a queue-based scoreboard of credits, responses and error flags.
module tb_sl_master_port;
  import sl_pkg::*;

  localparam int RT    = 4;
  localparam int DEPTH = 8;
  localparam int SLOTS = 32;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  id;
  } hreq_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  id;
  } hrsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic        host_wr = 1'b0;
  logic [15:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  SL_REQ       req_down;
  SL_RES       res_down = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_id;
  logic [3:0]  inflight;
  logic        err_unexpected, err_missing, err_id;

  int n_vec = 0;
  int n_mis = 0;

  // model state
  hreq_t       host_q[$];
  hrsp_t       exp_q[$];
  int          m_infl = 0;
  logic [3:0]  m_id = '0;
  logic        m_unexp = 1'b0, m_miss = 1'b0, m_eid = 1'b0;
  int          gen = 0;
  int          ncyc = 0;

  // fabric slots indexed by delivery cycle
  bit          s_exp [SLOTS];
  int          s_gen [SLOTS];
  SL_RES       s_res [SLOTS];
  logic [3:0]  s_mid [SLOTS];
  hrsp_t       s_x   [SLOTS];

  // fault knobs
  bit          fab_drop = 0, fab_corrupt = 0, fab_extra = 0, fab_force = 0;
  logic [31:0] fab_force_val = '0;

  sl_master_port #(.ROUND_TRIP(RT), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_wr        (host_wr),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .req_down       (req_down),
    .res_down       (res_down),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_id         (rsp_id),
    .inflight       (inflight),
    .err_unexpected (err_unexpected),
    .err_missing    (err_missing),
    .err_id         (err_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    host_wr    = 1'($urandom);
    host_addr  = 16'($urandom);
    host_wdata = $urandom;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    host_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      done = (m_infl == 0) && (exp_q.size() == 0) && (host_q.size() == 0);
    end
    chk("drain_done", 64'(done), 64'd1);
    chk("drain_inflight", 64'(inflight), 64'd0);
    chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  // Fabric + scoreboard, evaluated mid-cycle when all DUT outputs are settled.
  always @(negedge clk) begin
    int          k, j;
    hreq_t       hq;
    logic [31:0] rd;
    k = ncyc % SLOTS;
    j = (ncyc + RT) % SLOTS;
    ncyc++;
    if (!rst_n) begin
      host_q.delete();
      exp_q.delete();
      m_infl  = 0;
      m_id    = '0;
      m_unexp = 1'b0;
      m_miss  = 1'b0;
      m_eid   = 1'b0;
      gen++;
    end else begin
      chk("host_ready", 64'(host_ready), 64'((m_infl + exp_q.size()) < DEPTH));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
      chk("inflight", 64'(inflight), 64'(m_infl));
      chk("err_unexpected", 64'(err_unexpected), 64'(m_unexp));
      chk("err_missing", 64'(err_missing), 64'(m_miss));
      chk("err_id", 64'(err_id), 64'(m_eid));

      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
        chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
        void'(exp_q.pop_front());
      end

      if (req_down.valid) begin
        if (host_q.size() == 0) begin
          chk("req_spurious", 64'(req_down.valid), 64'd0);
        end else begin
          hq = host_q.pop_front();
          chk("req_wr", 64'(req_down.wr), 64'(hq.wr));
          chk("req_addr", 64'(req_down.addr), 64'(hq.addr));
          chk("req_wdata", 64'(req_down.wdata), 64'(hq.wdata));
          chk("req_id", 64'(req_down.id), 64'(hq.id));
          rd = fab_force ? fab_force_val : $urandom;
          s_exp[j] = 1;
          s_gen[j] = gen;
          s_mid[j] = hq.id;
          s_res[j] = '{valid: 1'b1, rdata: rd, id: req_down.id};
          s_x[j]   = '{rdata: rd, id: hq.id};
          if (fab_corrupt && hq.id == 4'd3) begin
            s_res[j].id = 4'd5;
            s_x[j].id   = 4'd5;
            fab_corrupt = 0;
          end
          if (fab_drop) begin
            s_res[j] = '0;
            s_x[j]   = '{rdata: 32'd0, id: hq.id};
            fab_drop = 0;
          end
        end
      end

      if (host_valid && host_ready) begin
        host_q.push_back('{wr: host_wr, addr: host_addr, wdata: host_wdata, id: m_id});
        m_id = m_id + 4'd1;
        m_infl++;
      end

      if (s_exp[k] && s_gen[k] == gen) begin
        m_infl--;
        exp_q.push_back(s_x[k]);
        if (!s_res[k].valid) m_miss = 1'b1;
        else if (s_res[k].id != s_mid[k]) m_eid = 1'b1;
      end else if (s_res[k].valid) begin
        m_unexp = 1'b1;
      end else if (fab_extra) begin
        s_res[k]  = '{valid: 1'b1, rdata: $urandom, id: 4'($urandom)};
        m_unexp   = 1'b1;
        fab_extra = 0;
      end
    end
    res_down = s_res[k];
    s_res[k] = '0;
    s_exp[k] = 0;
  end

  initial begin
    int nhs;
    for (int i = 0; i < SLOTS; i++) s_res[i] = '0;

    // reset values
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_host_ready", 64'(host_ready), 64'd1);
    chk("rst_req_down", 64'(req_down), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_errs", 64'({err_unexpected, err_missing, err_id}), 64'd0);
    rst_n = 1'b1;
    repeat (4) step();

    // single read with a fixed fabric payload
    fab_force     = 1;
    fab_force_val = 32'hDEADBEEF;
    host_valid = 1'b1;
    host_wr    = 1'b0;
    host_addr  = 16'h0010;
    host_wdata = $urandom;
    step();
    host_valid = 1'b0;
    chk("single_req_valid", 64'(req_down.valid), 64'd1);
    chk("single_req_id", 64'(req_down.id), 64'd0);
    chk("single_req_addr", 64'(req_down.addr), 64'h0010);
    step();
    chk("single_req_pulse", 64'(req_down.valid), 64'd0);
    repeat (RT - 1) step();
    chk("single_rsp_early", 64'(rsp_valid), 64'd0);
    step();
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("single_rsp_id", 64'(rsp_id), 64'd0);
    fab_force = 0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("single_inflight", 64'(inflight), 64'd0);
    chk("single_rsp_gone", 64'(rsp_valid), 64'd0);

    // back-to-back streaming, IDs wrap through 0
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_valid = 1'b1;
      drive_rand();
      chk("stream_ready", 64'(host_ready), 64'd1);
      step();
    end
    drain();

    // backpressure: exactly DEPTH credits
    rsp_ready = 1'b0;
    nhs = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      host_valid = 1'b1;
      drive_rand();
      if (host_ready) nhs++;
      step();
    end
    host_valid = 1'b0;
    chk("bp_handshakes", 64'(nhs), 64'(DEPTH));
    chk("bp_ready_low", 64'(host_ready), 64'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_ready_after_pop", 64'(host_ready), 64'd1);
    drain();

    // dropped response
    fab_drop   = 1;
    host_valid = 1'b1;
    drive_rand();
    step();
    host_valid = 1'b0;
    drain();
    chk("drop_err_missing", 64'(err_missing), 64'd1);

    // extra response in an idle slot
    fab_extra = 1;
    repeat (3) step();
    chk("extra_err_unexpected", 64'(err_unexpected), 64'd1);
    chk("extra_fifo_empty", 64'(rsp_valid), 64'd0);

    // corrupted ID 3 -> 5
    fab_corrupt = 1;
    rsp_ready   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_valid = 1'b1;
      drive_rand();
      step();
    end
    drain();
    chk("corrupt_err_id", 64'(err_id), 64'd1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      host_valid = 1'($urandom);
      drive_rand();
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // reset with three requests in flight
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1;
      drive_rand();
      step();
    end
    host_valid = 1'b0;
    chk("mid_inflight", 64'(inflight), 64'd3);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("mid_err_unexpected", 64'(err_unexpected), 64'd1);
    chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_inflight_zero", 64'(inflight), 64'd0);
    chk("mid_err_missing", 64'(err_missing), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
